// File: rtl/trap_unit.sv
// trap_unit: execute-stage jump/trap resolver. Computes branch and jump
// targets and selects between synchronous exceptions, mret and NUM_IRQ
// edge-latched external interrupts. A handler-active state blocks nested
// interrupts until mret.
module trap_unit #(
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter bit VECTORED       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush,
  input  logic [31:0]        pc,
  input  logic [31:0]        imm,
  input  logic [31:0]        rs1_rdata,
  input  logic               alu_zero,
  input  logic               base_src,
  input  logic [1:0]         cond,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               global_ie,
  input  logic               ins_illegal,
  input  logic               ins_misalign,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               store_misalign,
  input  logic               load_misalign,
  input  logic [31:0]        mtvec_rdata,
  input  logic               trap_return,
  input  logic [31:0]        mepc_rdata,
  output logic [31:0]        jump_target,
  output logic               branch_taken,
  output logic               trap_taken,
  output logic [4:0]         trap_cause,
  output logic               trap_is_int,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_handler
);

  localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {IDLE, HANDLER} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q;

  logic               exc, mret_ok, int_ok, irq_hit;
  logic [4:0]         exc_cause, int_cause;
  logic [IDXW-1:0]    irq_idx;
  logic [NUM_IRQ-1:0] masked;
  logic [31:0]        tbase, branch_sum;

  // Exception request and fixed-priority cause encoding.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    exc_cause = 5'd0;
    if      (ins_illegal)    exc_cause = 5'd2;
    else if (ins_misalign)   exc_cause = 5'd0;
    else if (ecall)          exc_cause = 5'd11;
    else if (ebreak)         exc_cause = 5'd3;
    else if (store_misalign) exc_cause = 5'd6;
    else if (load_misalign)  exc_cause = 5'd4;
  end

  assign exc = !pipe_flush && (ins_illegal || ins_misalign || ecall ||
                               ebreak || store_misalign || load_misalign);

  assign masked = pending_q & irq_enable;

  // Lowest enabled pending channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        irq_hit = 1'b1;
        irq_idx = IDXW'(i);
      end
    end
  end

  assign int_cause = 5'(IRQ_CAUSE_BASE) + 5'(irq_idx);

  // An exception in the same slot squashes the mret, so the handler stays active.
  assign mret_ok = trap_return && !pipe_flush && !exc;
  assign int_ok  = !pipe_flush && !exc && !trap_return && global_ie &&
                   (state_q == IDLE) && irq_hit;

  assign trap_taken  = exc || int_ok || (trap_return && !pipe_flush);
  assign trap_is_int = int_ok;
  assign trap_cause  = exc ? exc_cause : (int_ok ? int_cause : 5'b11111);
  assign irq_ack     = (int_ok && !rst) ? (NUM_IRQ'(1) << irq_idx) : '0;

  // Pending bits: a rising edge sets, an acknowledge clears, set wins.
  assign pending_d = (pending_q & ~irq_ack) | (irq & ~irq_prev_q);

  // Edge-capture and pending registers. irq_prev keeps tracking the line
  // through reset so a level held across reset is not seen as a new edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    irq_prev_q <= irq;
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Handler state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handler next-state: enter on an accepted interrupt, leave on a taken mret.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (int_ok)  state_d = HANDLER;
      HANDLER: if (mret_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_handler  = (state_q == HANDLER);
  assign irq_pending = pending_q;

  // Branch condition decode; independent of any trap.
  always_comb begin
    case (cond)
      2'd0:    branch_taken = 1'b0;
      2'd1:    branch_taken = 1'b1;
      2'd2:    branch_taken = alu_zero;
      default: branch_taken = !alu_zero;
    endcase
  end

  assign tbase = {mtvec_rdata[31:2], 2'b00};

  // Redirect target: exception, then interrupt, then mret, then jump/branch.
  always_comb begin
    branch_sum = (base_src ? rs1_rdata : pc) + imm;
    if (base_src) branch_sum[0] = 1'b0;
    if (exc)
      jump_target = tbase;
    else if (int_ok)
      jump_target = (VECTORED && mtvec_rdata[1:0] == 2'b01)
                    ? tbase + {25'd0, int_cause, 2'b00} : tbase;
    else if (trap_return && !pipe_flush)
      jump_target = mepc_rdata;
    else
      jump_target = branch_sum;
  end

endmodule
